// File: rtl/ge_seq_ctrl_if.sv
// Bus bundle between the Gaussian-elimination sequencer and its surroundings:
// job control/status, source row memory, comb_SA handshake and destination
// row memory. The sequencer is the master; memories, array and host form the
// slave side.
interface ge_seq_ctrl_if #(
   parameter int DAT_W = 64,
   parameter int AW    = 6,
   parameter int CNT_W = 16
);
   // Job control and status
   logic             start;
   logic             busy;
   logic             done;
   logic             full_rank_o;
   logic             error;
   logic [CNT_W-1:0] cycles;

   // Source row memory (registered read, one cycle latency)
   logic [AW-1:0]    src_rd_addr;
   logic             src_rden;
   logic [DAT_W-1:0] src_q;

   // comb_SA handshake
   logic             sa_mode;
   logic             sa_start;
   logic [DAT_W-1:0] sa_data;
   logic             sa_finish;
   logic             sa_full_rank;
   logic [DAT_W-1:0] sa_result;

   // Destination row memory
   logic [AW-1:0]    dst_wr_addr;
   logic             dst_wren;
   logic [DAT_W-1:0] dst_wr_data;

   modport master (
      input  start, src_q, sa_finish, sa_full_rank, sa_result,
      output busy, done, full_rank_o, error, cycles,
             src_rd_addr, src_rden,
             sa_mode, sa_start, sa_data,
             dst_wr_addr, dst_wren, dst_wr_data
   );

   modport slave (
      output start, src_q, sa_finish, sa_full_rank, sa_result,
      input  busy, done, full_rank_o, error, cycles,
             src_rd_addr, src_rden,
             sa_mode, sa_start, sa_data,
             dst_wr_addr, dst_wren, dst_wr_data
   );
endinterface

// File: rtl/ge_seq_ctrl.sv
// Job sequencer for the comb_SA Gaussian-elimination array. One start runs a
// whole job: stream the source rows into the array (triangularize), systemize
// when the matrix turned out full rank, then drain the result rows into the
// destination memory from the top address down. Reports done, rank, a wait
// timeout and the number of cycles the job took.
module ge_seq_ctrl #(
   parameter int DAT_W   = 64,
   parameter int DAT_D   = 64,
   parameter int AW      = 6,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input logic           clk,
   input logic           rst_b,
   ge_seq_ctrl_if.master bus
);

   // Wait counter must be able to hold TIMEOUT-1
   localparam int             WCW       = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0]  LAST_ROW  = AW'(DAT_D - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      PREFETCH,
      LOAD,
      WAIT_TRI,
      SYS_START,
      WAIT_SYS,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q;
   logic [AW-1:0]    loadCnt_q;
   logic [WCW-1:0]   waitCnt_q;
   logic             finishDly_q;

   logic             busy_q;
   logic             done_q;
   logic             fullRank_q;
   logic             error_q;
   logic [CNT_W-1:0] cycles_q;
   logic [AW-1:0]    srcRdAddr_q;
   logic             srcRden_q;
   logic             saMode_q;
   logic             saStart_q;
   logic [AW-1:0]    dstWrAddr_q;
   logic             dstWren_q;

   logic [CNT_W-1:0] cycles_d;
   logic             finishRise;
   logic             waitExpired;

   // A finish only counts as a fresh 0->1 edge, so a level still high from an
   // earlier phase can never advance a wait state.
   assign finishRise  = bus.sa_finish & ~finishDly_q;
   assign waitExpired = (waitCnt_q == WAIT_LAST);

   // Saturating job cycle counter: it sticks at all-ones instead of wrapping
   assign cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

   // Main sequencer: state, counters and every registered output
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         loadCnt_q   <= '0;
         waitCnt_q   <= '0;
         finishDly_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fullRank_q  <= 1'b0;
         error_q     <= 1'b0;
         cycles_q    <= '0;
         srcRdAddr_q <= '0;
         srcRden_q   <= 1'b0;
         saMode_q    <= 1'b0;
         saStart_q   <= 1'b0;
         dstWrAddr_q <= '0;
         dstWren_q   <= 1'b0;
      end else begin
         finishDly_q <= bus.sa_finish;
         done_q      <= 1'b0;
         saStart_q   <= 1'b0;

         if (state_q != IDLE) begin
            cycles_q <= cycles_d;
         end

         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q     <= PREFETCH;
                  busy_q      <= 1'b1;
                  cycles_q    <= '0;
                  error_q     <= 1'b0;
                  fullRank_q  <= 1'b0;
                  saMode_q    <= 1'b0;
                  srcRden_q   <= 1'b1;
                  srcRdAddr_q <= '0;
               end
            end

            PREFETCH: begin
               // Row 0 arrives next cycle; row 1 is requested alongside it
               state_q     <= LOAD;
               loadCnt_q   <= '0;
               saStart_q   <= 1'b1;
               srcRden_q   <= (DAT_D > 1);
               srcRdAddr_q <= AW'(1);
            end

            LOAD: begin
               if (loadCnt_q == LAST_ROW) begin
                  state_q   <= WAIT_TRI;
                  waitCnt_q <= '0;
                  srcRden_q <= 1'b0;
               end else begin
                  loadCnt_q <= loadCnt_q + AW'(1);
                  if (int'(loadCnt_q) + 2 < DAT_D) begin
                     srcRden_q   <= 1'b1;
                     srcRdAddr_q <= srcRdAddr_q + AW'(1);
                  end else begin
                     srcRden_q <= 1'b0;
                  end
               end
            end

            WAIT_TRI: begin
               if (finishRise) begin
                  fullRank_q <= bus.sa_full_rank;
                  if (bus.sa_full_rank) begin
                     state_q   <= SYS_START;
                     saMode_q  <= 1'b1;
                     saStart_q <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end else if (waitExpired) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  error_q    <= 1'b1;
                  fullRank_q <= 1'b0;
               end else begin
                  waitCnt_q <= waitCnt_q + WCW'(1);
               end
            end

            SYS_START: begin
               state_q   <= WAIT_SYS;
               waitCnt_q <= '0;
            end

            WAIT_SYS: begin
               if (finishRise) begin
                  fullRank_q  <= bus.sa_full_rank;
                  state_q     <= DRAIN;
                  dstWren_q   <= 1'b1;
                  dstWrAddr_q <= LAST_ROW;
               end else if (waitExpired) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  error_q    <= 1'b1;
                  fullRank_q <= 1'b0;
               end else begin
                  waitCnt_q <= waitCnt_q + WCW'(1);
               end
            end

            DRAIN: begin
               // The write address itself counts the drain down to row 0
               if (dstWrAddr_q == '0) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  dstWren_q <= 1'b0;
               end else begin
                  dstWrAddr_q <= dstWrAddr_q - AW'(1);
               end
            end

            DONE: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               saMode_q <= 1'b0;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.full_rank_o = fullRank_q;
   assign bus.error       = error_q;
   assign bus.cycles      = cycles_q;
   assign bus.src_rd_addr = srcRdAddr_q;
   assign bus.src_rden    = srcRden_q;
   assign bus.sa_mode     = saMode_q;
   assign bus.sa_start    = saStart_q;
   assign bus.dst_wr_addr = dstWrAddr_q;
   assign bus.dst_wren    = dstWren_q;

   // Row data reaches the array only while loading; zero otherwise
   assign bus.sa_data     = (state_q == LOAD) ? bus.src_q : {DAT_W{1'b0}};

   // Result rows pass straight through to the destination memory
   assign bus.dst_wr_data = bus.sa_result;

endmodule

// File: tb/tb_ge_seq_ctrl.sv
// Directed bench for ge_seq_ctrl: small 4x8 matrix, a behavioural source
// memory and comb_SA model, and hand-computed expectations for nominal,
// rank-deficient, timeout, spurious-start/stale-finish, mid-drain reset and
// back-to-back jobs. A second instance with a 4-bit cycle counter shares the
// stimulus so counter saturation is visible.
module tb_ge_seq_ctrl;

   localparam int DAT_W   = 8;
   localparam int DAT_D   = 4;
   localparam int AW      = 2;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 16;
   localparam int SAT_W   = 4;

   // Finish is raised in the 5th cycle of each wait state, counted from the
   // cycle in which the matching sa_start was seen.
   localparam int TRI_AT = DAT_D + 4;
   localparam int SYS_AT = 5;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;

   always #5 clk = ~clk;

   ge_seq_ctrl_if #(.DAT_W(DAT_W), .AW(AW), .CNT_W(CNT_W)) bus ();
   ge_seq_ctrl_if #(.DAT_W(DAT_W), .AW(AW), .CNT_W(SAT_W)) busSat ();

   ge_seq_ctrl #(
      .DAT_W(DAT_W), .DAT_D(DAT_D), .AW(AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus)
   );

   ge_seq_ctrl #(
      .DAT_W(DAT_W), .DAT_D(DAT_D), .AW(AW), .TIMEOUT(TIMEOUT), .CNT_W(SAT_W)
   ) dutSat (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (busSat)
   );

   // Stimulus-side variables feeding both instances
   logic             startIn  = 1'b0;
   logic [DAT_W-1:0] srcQ     = '0;
   logic             saFinish = 1'b0;
   logic             saRank   = 1'b0;
   logic [DAT_W-1:0] saResult = '0;

   assign bus.start           = startIn;
   assign bus.src_q           = srcQ;
   assign bus.sa_finish       = saFinish;
   assign bus.sa_full_rank    = saRank;
   assign bus.sa_result       = saResult;
   assign busSat.start        = startIn;
   assign busSat.src_q        = srcQ;
   assign busSat.sa_finish    = saFinish;
   assign busSat.sa_full_rank = saRank;
   assign busSat.sa_result    = saResult;

   // SA model configuration, set by the main sequence between jobs
   logic rankTri     = 1'b1;
   logic rankSys     = 1'b1;
   logic neverFinish = 1'b0;
   logic staleFinish = 1'b0;

   logic saActive = 1'b0;
   logic saMode   = 1'b0;
   int   saT      = 0;
   int   sysStarts = 0;
   int   triStarts = 0;

   logic [8:0]  saDataQ[$];
   logic [9:0]  dstQ[$];

   int checkCount = 0;
   int errCount   = 0;
   int saBase, dstBase, sysBase, triBase;

   // Source memory: row k holds 0x11*(k+1), one-cycle registered read
   always @(posedge clk) begin
      if (bus.src_rden) begin
         srcQ <= 8'((int'(bus.src_rd_addr) + 1) * 'h11);
      end
   end

   // comb_SA model: times finish from its own start and streams A0.. after
   // a systemize finish
   always @(posedge clk) begin
      #1;
      if (!rst_b) begin
         saActive = 1'b0;
      end else if (bus.sa_start) begin
         saActive = 1'b1;
         saMode   = bus.sa_mode;
         saT      = 0;
         if (bus.sa_mode) sysStarts++;
         else             triStarts++;
      end else if (saActive) begin
         saT++;
      end
      saFinish = 1'b0;
      saResult = '0;
      if (saActive && !neverFinish) begin
         if (!saMode) begin
            saFinish = staleFinish ? (saT >= TRI_AT) : (saT == TRI_AT);
         end else begin
            saFinish = (saT == SYS_AT) || (staleFinish && saT <= 2);
            if (saT > SYS_AT && saT <= SYS_AT + DAT_D) begin
               saResult = 8'('hA0 + saT - SYS_AT - 1);
            end
         end
      end
      saRank = saMode ? rankSys : rankTri;
   end

   // Traffic monitor: rows handed to the array and destination writes
   always @(negedge clk) begin
      if (bus.sa_data != '0) saDataQ.push_back({bus.sa_start, bus.sa_data});
      if (bus.dst_wren)      dstQ.push_back({bus.dst_wr_addr, bus.dst_wr_data});
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of sequence, expected finish before 100000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Run one job from an IDLE negedge; returns at the first IDLE negedge after done
   task automatic applyStimulus(input string tag, input int expDoneIdx,
                                input int expCycles, input int expSat,
                                input logic expRank, input logic expErr,
                                input bit spurious);
      int idx;
      saBase  = saDataQ.size();
      dstBase = dstQ.size();
      sysBase = sysStarts;
      triBase = triStarts;
      startIn = 1'b1;
      @(negedge clk);
      startIn = 1'b0;
      checkOutput({tag, ".busy"}, bus.busy, 1);
      checkOutput({tag, ".errClr"}, bus.error, 0);
      idx = -1;
      for (int i = 0; i < 200; i++) begin
         if (spurious) startIn = (i == 2);
         if (bus.done) begin
            idx = i;
            break;
         end
         @(negedge clk);
      end
      if (spurious) startIn = 1'b1;
      checkOutput({tag, ".doneAt"}, idx, expDoneIdx);
      checkOutput({tag, ".busyAtDone"}, bus.busy, 1);
      @(negedge clk);
      startIn = 1'b0;
      checkOutput({tag, ".idleFlags"}, {bus.busy, bus.done, bus.sa_mode}, 3'b000);
      checkOutput({tag, ".cycles"}, bus.cycles, expCycles);
      checkOutput({tag, ".satCycles"}, busSat.cycles, expSat);
      checkOutput({tag, ".fullRank"}, bus.full_rank_o, expRank);
      checkOutput({tag, ".error"}, bus.error, expErr);
   endtask

   // Compare the rows/writes seen since the job started against the fixed matrix
   task automatic checkTraffic(input string tag, input bit expDrain, input int expSys);
      logic [35:0] saPacked;
      logic [39:0] dstPacked;
      int nSa, nDst;
      nSa  = saDataQ.size() - saBase;
      nDst = dstQ.size() - dstBase;
      saPacked  = '0;
      dstPacked = '0;
      for (int i = 0; i < 4; i++) begin
         saPacked  = {saPacked[26:0], (i < nSa) ? saDataQ[saBase + i] : 9'h000};
         dstPacked = {dstPacked[29:0], (i < nDst) ? dstQ[dstBase + i] : 10'h000};
      end
      checkOutput({tag, ".saRows"}, nSa, 4);
      checkOutput({tag, ".saData"}, saPacked, {9'h111, 9'h022, 9'h033, 9'h044});
      checkOutput({tag, ".triStarts"}, triStarts - triBase, 1);
      checkOutput({tag, ".sysStarts"}, sysStarts - sysBase, expSys);
      checkOutput({tag, ".dstWrites"}, nDst, expDrain ? 4 : 0);
      if (expDrain) begin
         checkOutput({tag, ".dstData"}, dstPacked,
                     {10'h3A0, 10'h2A1, 10'h1A2, 10'h0A3});
      end
   endtask

   initial begin
      int   seen;
      logic lateBusy;

      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("rst.flags", {bus.busy, bus.done, bus.full_rank_o, bus.error,
                                bus.src_rden, bus.sa_mode, bus.sa_start, bus.dst_wren}, 8'h00);
      checkOutput("rst.cycles", bus.cycles, 0);
      checkOutput("rst.addr", {bus.src_rd_addr, bus.dst_wr_addr}, 4'h0);
      checkOutput("rst.saData", bus.sa_data, 0);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal job, then a second one started in the first IDLE cycle
      applyStimulus("nom", 20, 21, 15, 1'b1, 1'b0, 1'b0);
      checkTraffic("nom", 1'b1, 1);
      applyStimulus("b2b", 20, 21, 15, 1'b1, 1'b0, 1'b0);
      checkTraffic("b2b", 1'b1, 1);

      // Rank deficient: no systemize, no drain
      rankTri = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus("rdef", 10, 11, 11, 1'b0, 1'b0, 1'b0);
      checkTraffic("rdef", 1'b0, 0);
      rankTri = 1'b1;

      // Array never finishes: timeout after TIMEOUT wait cycles
      neverFinish = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus("tmo", 13, 14, 14, 1'b0, 1'b1, 1'b0);
      checkTraffic("tmo", 1'b0, 0);
      neverFinish = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("tmo.errHeld", bus.error, 1);

      // Spurious starts in LOAD and DONE, finish held high into WAIT_SYS;
      // this job also shows the error flag clearing on acceptance
      staleFinish = 1'b1;
      applyStimulus("spur", 20, 21, 15, 1'b1, 1'b0, 1'b1);
      checkTraffic("spur", 1'b1, 1);
      lateBusy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         lateBusy = lateBusy | bus.busy;
      end
      checkOutput("spur.noSecondJob", lateBusy, 0);
      checkOutput("spur.noExtraRows", saDataQ.size() - saBase, 4);
      staleFinish = 1'b0;
      repeat (2) @(negedge clk);

      // Reset after two drain writes
      dstBase = dstQ.size();
      startIn = 1'b1;
      @(negedge clk);
      startIn = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && seen < 2; i++) begin
         @(negedge clk);
         if (bus.dst_wren) seen++;
      end
      checkOutput("rstDrain.writesBefore", seen, 2);
      rst_b = 1'b0;
      @(negedge clk);
      checkOutput("rstDrain.flags", {bus.busy, bus.done, bus.full_rank_o, bus.error,
                                     bus.src_rden, bus.sa_mode, bus.sa_start, bus.dst_wren}, 8'h00);
      checkOutput("rstDrain.cycles", bus.cycles, 0);
      checkOutput("rstDrain.addr", {bus.src_rd_addr, bus.dst_wr_addr}, 4'h0);
      @(negedge clk);
      rst_b = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("rstDrain.noMoreWrites", dstQ.size() - dstBase, 2);

      // A full job still runs after the abort
      applyStimulus("post", 20, 21, 15, 1'b1, 1'b0, 1'b0);
      checkTraffic("post", 1'b1, 1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
